order_egress_serializer: RTL

- Consumes the per-order register bank (7 x REG_WIDTH words plus a valid strobe) produced by the reverse_parser stage at the tail of hft_top.
- Buffers whole messages in a small FIFO.
- Replays each message as a word-serial stream with valid/ready handshake and start/end markers toward the host/network egress interface.
- Decouples the single-cycle reverse_parser output from a slower or back-pressuring consumer, and counts messages dropped on overflow.

---
 rtl/hft_pkg.sv | 23 ++
 rtl/msg_fifo.sv | 93 +++++++++
 rtl/order_egress_serializer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/hft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hft_pkg
// Description : Shared definitions for the order egress path: default word
//               geometry, egress FSM state type and the whole-message type.
// Revision    : 1.0 - initial release
// ============================================================================
package hft_pkg;

    localparam int REG_WIDTH_DEF = 32;
    localparam int NUM_REGS_DEF  = 7;

    // Egress serializer states, explicit one-bit encoding.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } egress_state_t;

    // One complete message; element 0 is the first word on the wire.
    typedef logic [NUM_REGS_DEF-1:0][REG_WIDTH_DEF-1:0] msg_t;

endpackage : hft_pkg
`default_nettype wire

// File: rtl/msg_fifo.sv
`default_nettype none
// ============================================================================
// Module      : msg_fifo
// Description : Whole-message FIFO with a word-select read port.
//               Ports: i_clk/i_reset_n clock and async active-low reset;
//               i_push/i_msg write request and message; i_pop releases the
//               head slot; i_word_idx selects a word of the head message
//               (o_rd_word); o_full/o_empty status from registered count;
//               o_push_drop flags a push rejected because the FIFO is full;
//               o_count_next_zero says the FIFO is empty after this edge.
// Revision    : 1.0 - initial release
// ============================================================================
module msg_fifo
    import hft_pkg::*;
#(
    parameter int REG_WIDTH  = REG_WIDTH_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1),
    localparam int IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                               i_clk,
    input  logic                               i_reset_n,
    input  logic                               i_push,
    input  logic [NUM_REGS-1:0][REG_WIDTH-1:0] i_msg,
    input  logic                               i_pop,
    input  logic [IDX_W-1:0]                   i_word_idx,
    output logic                               o_full,
    output logic                               o_empty,
    output logic                               o_push_drop,
    output logic                               o_count_next_zero,
    output logic [REG_WIDTH-1:0]               o_rd_word
);

    logic [NUM_REGS-1:0][REG_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic w_push_ok;

    assign o_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign o_empty = (count_q == '0);

    // Full is judged on the registered count only: a pop completing in the
    // same cycle does not make room, so the head slot is never overwritten.
    assign w_push_ok   = i_push && !o_full;
    assign o_push_drop = i_push &&  o_full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (i_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_push_ok, i_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    assign o_count_next_zero = (count_d == '0);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Message storage carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= i_msg;
        end
    end

    assign o_rd_word = mem_q[rd_ptr_q][i_word_idx];

endmodule : msg_fifo
`default_nettype wire

// File: rtl/order_egress_serializer.sv
`default_nettype none
// ============================================================================
// Module      : order_egress_serializer
// Description : Buffers 7-word order messages from the reverse parser and
//               replays them as a valid/ready word stream with sop/last marks.
//               Ports: i_clk/i_reset_n clock and async active-low reset;
//               i_reg_1..i_reg_7 + i_valid message input (i_reg_1 = word 0);
//               o_fifo_full buffer status; o_tx_data/o_tx_valid/i_tx_ready
//               stream handshake with o_tx_sop/o_tx_last markers;
//               o_drop_count saturating count of messages lost to overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module order_egress_serializer
    import hft_pkg::*;
#(
    parameter int REG_WIDTH      = REG_WIDTH_DEF,
    parameter int NUM_REGS       = NUM_REGS_DEF,
    parameter int FIFO_DEPTH     = 4,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [REG_WIDTH-1:0]      i_reg_1,
    input  logic [REG_WIDTH-1:0]      i_reg_2,
    input  logic [REG_WIDTH-1:0]      i_reg_3,
    input  logic [REG_WIDTH-1:0]      i_reg_4,
    input  logic [REG_WIDTH-1:0]      i_reg_5,
    input  logic [REG_WIDTH-1:0]      i_reg_6,
    input  logic [REG_WIDTH-1:0]      i_reg_7,
    input  logic                      i_valid,
    output logic                      o_fifo_full,
    output logic [REG_WIDTH-1:0]      o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    output logic                      o_tx_sop,
    output logic                      o_tx_last,
    output logic [DROP_CNT_WIDTH-1:0] o_drop_count
);

    localparam int IDX_W = $clog2(NUM_REGS);

    egress_state_t              state_q, state_d;
    logic [IDX_W-1:0]           word_idx_q, word_idx_d;
    logic [DROP_CNT_WIDTH-1:0]  drop_count_q, drop_count_d;

    logic [NUM_REGS-1:0][REG_WIDTH-1:0] w_msg;
    logic [REG_WIDTH-1:0]               w_rd_word;
    logic w_send, w_last, w_fire, w_pop;
    logic w_fifo_empty, w_push_drop, w_count_next_zero;

    assign w_msg = {i_reg_7, i_reg_6, i_reg_5, i_reg_4, i_reg_3, i_reg_2, i_reg_1};

    assign w_send = (state_q == SEND);
    assign w_last = (word_idx_q == IDX_W'(NUM_REGS - 1));
    assign w_fire = w_send && i_tx_ready;
    assign w_pop  = w_fire && w_last;

    msg_fifo #(
        .REG_WIDTH  (REG_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_msg_fifo (
        .i_clk             (i_clk),
        .i_reset_n         (i_reset_n),
        .i_push            (i_valid),
        .i_msg             (w_msg),
        .i_pop             (w_pop),
        .i_word_idx        (word_idx_q),
        .o_full            (o_fifo_full),
        .o_empty           (w_fifo_empty),
        .o_push_drop       (w_push_drop),
        .o_count_next_zero (w_count_next_zero),
        .o_rd_word         (w_rd_word)
    );

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        case (state_q)
            IDLE: begin
                if (!w_fifo_empty) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (w_fire) begin
                    if (w_last) begin
                        word_idx_d = '0;
                        // Staying in SEND here is what gives gap-free
                        // back-to-back messages.
                        if (w_count_next_zero) begin
                            state_d = IDLE;
                        end
                    end else begin
                        word_idx_d = word_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        drop_count_d = drop_count_q;
        if (w_push_drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + DROP_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            word_idx_q   <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            drop_count_q <= drop_count_d;
        end
    end

    // All stream outputs derive from registered state only, so they clear
    // the instant reset asserts and never depend on i_tx_ready.
    assign o_tx_valid   = w_send;
    assign o_tx_data    = w_send ? w_rd_word : '0;
    assign o_tx_sop     = w_send && (word_idx_q == '0);
    assign o_tx_last    = w_send && w_last;
    assign o_drop_count = drop_count_q;

endmodule : order_egress_serializer
`default_nettype wire
